// File: rtl/delta_credit_gate_if.sv
// Request streams and counter-command bundle between a requester/counter
// pair and the delta_credit_gate.
interface delta_credit_gate_if #(
    parameter int WIDTH = 4
);
    logic             inc_valid_i;
    logic             inc_ready_o;
    logic [WIDTH-1:0] inc_delta_i;
    logic             dec_valid_i;
    logic             dec_ready_o;
    logic [WIDTH-1:0] dec_delta_i;
    logic             cnt_clear_o;
    logic             cnt_en_o;
    logic             cnt_down_o;
    logic [WIDTH-1:0] cnt_delta_o;
    logic [WIDTH-1:0] avail_o;

    modport master (
        output inc_valid_i, inc_delta_i, dec_valid_i, dec_delta_i,
        input  inc_ready_o, dec_ready_o, cnt_clear_o, cnt_en_o,
               cnt_down_o, cnt_delta_o, avail_o
    );

    modport slave (
        input  inc_valid_i, inc_delta_i, dec_valid_i, dec_delta_i,
        output inc_ready_o, dec_ready_o, cnt_clear_o, cnt_en_o,
               cnt_down_o, cnt_delta_o, avail_o
    );
endinterface

// File: rtl/delta_credit_gate.sv
// Credit-checking command stage for the up/down delta counter: arbitrates inc/dec
// requests onto one registered command and refuses anything that would wrap.
module delta_credit_gate #(
    parameter int WIDTH      = 4,
    parameter int MAX_CREDIT = (2 ** WIDTH) - 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    delta_credit_gate_if.slave  bus
);

    if ((MAX_CREDIT < 1) || (MAX_CREDIT > ((2 ** WIDTH) - 1))) begin : g_bad_max
        $error("delta_credit_gate: MAX_CREDIT out of range 1..2**WIDTH-1");
    end

    localparam logic [WIDTH:0] MAX_W1 = (WIDTH + 1)'(MAX_CREDIT);

    logic [WIDTH-1:0] shadow_r;
    logic             last_was_dec_r;
    logic             cnt_clear_r;
    logic             cnt_en_r;
    logic             cnt_down_r;
    logic [WIDTH-1:0] cnt_delta_r;

    logic [WIDTH:0]   inc_sum_s;
    logic             inc_elig_s;
    logic             dec_elig_s;
    logic             grant_inc_s;
    logic             grant_dec_s;

    // Eligibility against the registered shadow, widened so the sum cannot wrap
    always_comb begin
        inc_sum_s  = {1'b0, shadow_r} + {1'b0, bus.inc_delta_i};
        inc_elig_s = bus.inc_valid_i && (inc_sum_s <= MAX_W1);
        dec_elig_s = bus.dec_valid_i && (bus.dec_delta_i <= shadow_r);
    end

    // Round-robin grant; a tie goes to the side not granted last
    always_comb begin
        grant_inc_s = 1'b0;
        grant_dec_s = 1'b0;
        if (clear_i) begin
            grant_inc_s = 1'b0;
            grant_dec_s = 1'b0;
        end else if (inc_elig_s && dec_elig_s) begin
            grant_inc_s = last_was_dec_r;
            grant_dec_s = !last_was_dec_r;
        end else begin
            grant_inc_s = inc_elig_s;
            grant_dec_s = dec_elig_s;
        end
    end

    assign bus.inc_ready_o = grant_inc_s;
    assign bus.dec_ready_o = grant_dec_s;

    // Shadow credit, arbitration pointer and the registered counter command
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_r       <= {WIDTH{1'b0}};
            last_was_dec_r <= 1'b0;
            cnt_clear_r    <= 1'b0;
            cnt_en_r       <= 1'b0;
            cnt_down_r     <= 1'b0;
            cnt_delta_r    <= {WIDTH{1'b0}};
        end else if (clear_i) begin
            shadow_r    <= {WIDTH{1'b0}};
            cnt_clear_r <= 1'b1;
            cnt_en_r    <= 1'b0;
            cnt_down_r  <= 1'b0;
            cnt_delta_r <= {WIDTH{1'b0}};
        end else if (grant_inc_s) begin
            shadow_r       <= inc_sum_s[WIDTH-1:0];
            last_was_dec_r <= 1'b0;
            cnt_clear_r    <= 1'b0;
            cnt_en_r       <= (bus.inc_delta_i != {WIDTH{1'b0}});
            cnt_down_r     <= 1'b0;
            cnt_delta_r    <= bus.inc_delta_i;
        end else if (grant_dec_s) begin
            shadow_r       <= shadow_r - bus.dec_delta_i;
            last_was_dec_r <= 1'b1;
            cnt_clear_r    <= 1'b0;
            // A zero-delta decrement is a no-op command, so down is left low too
            cnt_en_r       <= (bus.dec_delta_i != {WIDTH{1'b0}});
            cnt_down_r     <= (bus.dec_delta_i != {WIDTH{1'b0}});
            cnt_delta_r    <= bus.dec_delta_i;
        end else begin
            cnt_clear_r <= 1'b0;
            cnt_en_r    <= 1'b0;
            cnt_down_r  <= 1'b0;
            cnt_delta_r <= {WIDTH{1'b0}};
        end
    end

    assign bus.cnt_clear_o = cnt_clear_r;
    assign bus.cnt_en_o    = cnt_en_r;
    assign bus.cnt_down_o  = cnt_down_r;
    assign bus.cnt_delta_o = cnt_delta_r;
    assign bus.avail_o     = shadow_r;

endmodule

// File: tb/tb_delta_credit_gate.sv
// Directed bench for delta_credit_gate (WIDTH=4, MAX_CREDIT=15) with
// hand-computed expectations checked by immediate assertions.
module tb_delta_credit_gate;

    logic clk_i;
    logic rst_i;
    logic clear_i;
    int   total;
    int   bad;

    delta_credit_gate_if #(.WIDTH(4)) bus ();

    delta_credit_gate #(.WIDTH(4), .MAX_CREDIT(15)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle's request inputs and let combinational ready settle
    task automatic drive(input logic iv, input logic [3:0] id,
                         input logic dv, input logic [3:0] dd, input logic clr);
        bus.inc_valid_i = iv;
        bus.inc_delta_i = id;
        bus.dec_valid_i = dv;
        bus.dec_delta_i = dd;
        clear_i         = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_rdy(input string tag, input logic ir, input logic dr);
        chk({tag, ".inc_ready"}, {7'd0, bus.inc_ready_o}, {7'd0, ir});
        chk({tag, ".dec_ready"}, {7'd0, bus.dec_ready_o}, {7'd0, dr});
    endtask

    task automatic chk_out(input string tag, input logic clr, input logic en,
                           input logic dn, input logic [3:0] dl, input logic [3:0] av);
        chk({tag, ".cnt_clear"}, {7'd0, bus.cnt_clear_o}, {7'd0, clr});
        chk({tag, ".cnt_en"},    {7'd0, bus.cnt_en_o},    {7'd0, en});
        chk({tag, ".cnt_down"},  {7'd0, bus.cnt_down_o},  {7'd0, dn});
        chk({tag, ".cnt_delta"}, {4'd0, bus.cnt_delta_o}, {4'd0, dl});
        chk({tag, ".avail"},     {4'd0, bus.avail_o},     {4'd0, av});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clk_i = 1'b0;
        rst_i = 1'b1;
        clear_i = 1'b0;
        bus.inc_valid_i = 1'b0;
        bus.inc_delta_i = 4'd0;
        bus.dec_valid_i = 1'b0;
        bus.dec_delta_i = 4'd0;
        #12;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        rst_i = 1'b0;

        // inc 5 from empty
        drive(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        chk_rdy("inc5", 1'b1, 1'b0);
        tick();
        chk_out("inc5", 1'b0, 1'b1, 1'b0, 4'd5, 4'd5);

        // dec 7 underflows, stays pending
        drive(1'b0, 4'd0, 1'b1, 4'd7, 1'b0);
        chk_rdy("dec7_refused", 1'b0, 1'b0);
        tick();
        chk_out("dec7_refused", 1'b0, 1'b0, 1'b0, 4'd0, 4'd5);

        // inc 3 passes the blocked dec
        drive(1'b1, 4'd3, 1'b1, 4'd7, 1'b0);
        chk_rdy("inc3_bypass", 1'b1, 1'b0);
        tick();
        chk_out("inc3_bypass", 1'b0, 1'b1, 1'b0, 4'd3, 4'd8);

        drive(1'b0, 4'd0, 1'b1, 4'd7, 1'b0);
        chk_rdy("dec7_ok", 1'b0, 1'b1);
        tick();
        chk_out("dec7_ok", 1'b0, 1'b1, 1'b1, 4'd7, 4'd1);

        drive(1'b1, 4'd11, 1'b0, 4'd0, 1'b0);
        tick();
        chk_out("inc11", 1'b0, 1'b1, 1'b0, 4'd11, 4'd12);

        // overflow boundary at MAX_CREDIT=15
        drive(1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
        chk_rdy("inc4_ovf", 1'b0, 1'b0);
        tick();
        chk_out("inc4_ovf", 1'b0, 1'b0, 1'b0, 4'd0, 4'd12);

        drive(1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
        chk_rdy("inc3_to_max", 1'b1, 1'b0);
        tick();
        chk_out("inc3_to_max", 1'b0, 1'b1, 1'b0, 4'd3, 4'd15);

        drive(1'b1, 4'd1, 1'b0, 4'd0, 1'b0);
        chk_rdy("inc1_full", 1'b0, 1'b0);
        tick();
        chk_out("inc1_full", 1'b0, 1'b0, 1'b0, 4'd0, 4'd15);

        drive(1'b0, 4'd0, 1'b1, 4'd7, 1'b0);
        tick();
        chk_out("dec7_to8", 1'b0, 1'b1, 1'b1, 4'd7, 4'd8);

        // zero-delta inc: accepted, no counter enable, pointer back to 0
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        chk_rdy("inc0", 1'b1, 1'b0);
        tick();
        chk_out("inc0", 1'b0, 1'b0, 1'b0, 4'd0, 4'd8);

        // tie: dec, inc, dec, inc
        drive(1'b1, 4'd2, 1'b1, 4'd2, 1'b0);
        chk_rdy("tie1", 1'b0, 1'b1);
        tick();
        chk_out("tie1", 1'b0, 1'b1, 1'b1, 4'd2, 4'd6);
        chk_rdy("tie2", 1'b1, 1'b0);
        tick();
        chk_out("tie2", 1'b0, 1'b1, 1'b0, 4'd2, 4'd8);
        chk_rdy("tie3", 1'b0, 1'b1);
        tick();
        chk_out("tie3", 1'b0, 1'b1, 1'b1, 4'd2, 4'd6);
        chk_rdy("tie4", 1'b1, 1'b0);
        tick();
        chk_out("tie4", 1'b0, 1'b1, 1'b0, 4'd2, 4'd8);

        drive(1'b1, 4'd1, 1'b0, 4'd0, 1'b0);
        tick();
        chk_out("inc1_to9", 1'b0, 1'b1, 1'b0, 4'd1, 4'd9);

        // clear: request blocked, one-cycle cnt_clear pulse
        drive(1'b1, 4'd1, 1'b0, 4'd0, 1'b1);
        chk_rdy("clear", 1'b0, 1'b0);
        tick();
        chk_out("clear_n1", 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        chk_out("clear_n2", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        // dec on empty refused; zero dec on empty accepted
        drive(1'b0, 4'd0, 1'b1, 4'd1, 1'b0);
        chk_rdy("dec1_empty", 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b1, 4'd0, 1'b0);
        chk_rdy("dec0_empty", 1'b0, 1'b1);
        tick();
        chk_out("dec0_empty", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        // asynchronous reset mid-stream
        drive(1'b1, 4'd6, 1'b0, 4'd0, 1'b0);
        tick();
        chk_out("inc6", 1'b0, 1'b1, 1'b0, 4'd6, 4'd6);
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        rst_i = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        rst_i = 1'b0;
        tick();
        chk_out("post_rst", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delta_credit_gate.md
Name: delta_credit_gate

Overview:
- Credit-checking command stage that sits directly upstream of the team's up/down delta counter and drives its `en`/`down`/`delta`/`clear` inputs.
- Accepts increment and decrement requests from two valid/ready streams and arbitrates them onto the counter's single delta port, at most one command per cycle.
- Keeps a shadow credit count and refuses any request that would overflow or underflow, so the downstream counter never wraps.

Parameters:
- WIDTH, 4: width of the deltas, the shadow count and the counter command.
- MAX_CREDIT, 2**WIDTH-1: upper bound of the shadow count. Must satisfy 1 ≤ MAX_CREDIT ≤ 2**WIDTH-1; elaboration error otherwise.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous clear of the shadow count and the counter.
- inc_valid_i  in  1  increment request valid.
- inc_ready_o  out  1  increment accepted this cycle.
- inc_delta_i  in  WIDTH  increment amount.
- dec_valid_i  in  1  decrement request valid.
- dec_ready_o  out  1  decrement accepted this cycle.
- dec_delta_i  in  WIDTH  decrement amount.
- cnt_clear_o  out  1  to counter clear input (registered).
- cnt_en_o  out  1  to counter enable (registered).
- cnt_down_o  out  1  to counter down select (registered).
- cnt_delta_o  out  WIDTH  to counter delta (registered).
- avail_o  out  WIDTH  current shadow credit count (registered).

Behaviour:
- Reset (async, rst_i=1) sets these to 0: shadow count, avail_o, cnt_clear_o, cnt_en_o, cnt_down_o, cnt_delta_o, and the arbitration pointer `last_was_dec`. Ready outputs are combinational and read 0 while clear_i=1.
- Eligibility, computed in WIDTH+1 bits:
  - inc_elig = inc_valid_i && (shadow + inc_delta_i ≤ MAX_CREDIT).
  - dec_elig = dec_valid_i && (dec_delta_i ≤ shadow).
  - Both use the current registered shadow only.
- Grant:
  - clear_i=1: no grant.
  - Only one eligible: grant it.
  - Both eligible: grant the side not granted last. last_was_dec=1 grants inc; last_was_dec=0 grants dec.
  - last_was_dec updates only on a grant.
  - Reset value 0 means dec wins the first tie.
- inc_ready_o / dec_ready_o = grant for that side. Ready depends combinationally on valid and delta; the handshake completes when valid && ready. An ineligible request stays pending without blocking the other side.
- Accepted inc: shadow ← shadow + delta next cycle; cnt_en_o=1, cnt_down_o=0, cnt_delta_o=delta next cycle.
- Accepted dec: shadow ← shadow - delta next cycle; cnt_en_o=1, cnt_down_o=1, cnt_delta_o=delta next cycle.
- Zero delta: always eligible and accepted normally; cnt_en_o stays 0, cnt_delta_o=0, shadow unchanged. It still takes part in arbitration and updates the pointer.
- No grant: cnt_en_o=0, cnt_down_o=0, cnt_delta_o=0 next cycle.
- Latency: handshake in cycle N → command valid in N+1 → counter value updated in N+2. avail_o tracks shadow, so it leads the counter output by one cycle.
- clear_i in cycle N:
  - shadow=0 and avail_o=0 at N+1.
  - cnt_clear_o=1 and cnt_en_o=0 for exactly cycle N+1.
  - Pending requests are not accepted in N. A command issued in N-1 still reaches the counter in N, and the clear overrides it at N+1.
- Invariant: shadow ≤ MAX_CREDIT at all times; the counter never overflows or underflows from commands issued by this block.
- Reset mid-operation: all state drops immediately; no command emitted after reset deasserts until a new handshake.

Test Plan:
- Reset then inc delta=5 → inc_ready_o=1 in cycle 0; cycle 1 cnt_en_o=1, cnt_down_o=0, cnt_delta_o=5; avail_o=5.
- From avail=5, dec delta=7 held valid → dec_ready_o=0, avail_o stays 5. Then inc delta=3 → accepted, avail=8; dec of 7 then accepted the next cycle, avail=1, cnt_down_o=1, cnt_delta_o=7.
- WIDTH=4, MAX_CREDIT=15, avail=12: inc delta=4 → refused. Inc delta=3 → accepted, avail=15. Next inc delta=1 → refused.
- avail=8, inc=2 and dec=2 both valid for 4 cycles from reset pointer → grants alternate dec, inc, dec, inc; avail sequence 6, 8, 6, 8.
- avail=9, clear_i=1 with inc delta=1 valid → inc_ready_o=0. Next cycle cnt_clear_o=1, cnt_en_o=0, avail_o=0; the cycle after, cnt_clear_o=0.
- Inc delta=0 → inc_ready_o=1, next cycle cnt_en_o=0, avail_o unchanged. Assert rst_i mid-stream with avail=6 → avail_o=0 and all cnt_* outputs 0 immediately.
